pkt_dispatch_queue: RTL and testbench
=====================================

Name: pkt_dispatch_queue

Overview:
- Parametrised successor to the node's packet filter.
- Classifies each incoming packet and screens out masked or reserved types.
- Buffers accepted packets in a small FIFO and issues one-cycle enable pulses (QTU/MNI/KCH/reward) to the downstream unit, one packet at a time.
- Waits for a done handshake, with a timeout, before issuing the next packet. Sits between the packet parser and the Q-table/cluster-head/MNI units.

Parameters:
- WORD_WIDTH, 16, width of node/destination IDs.
- FIFO_DEPTH, 4, pending-packet entries; power of 2, at least 2.
- CNT_WIDTH, 8, width of the saturating statistics counters.
- TYPE_MASK, 8'h0F, bit t=1 accepts packet type t; types with mask 0 are dropped.
- BCAST_ID, all-ones of WORD_WIDTH, destination ID that matches every node.
- TIMEOUT, 64, maximum WAIT cycles before the dispatch is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- newpkt  in  1  one-cycle strobe; fPktType and destinationID are valid.
- fPktType  in  3  packet type: 000 HB, 001 CHE, 010 INV, 011 DATA, 1xx reserved.
- myNodeID  in  WORD_WIDTH  this node's ID, sampled with newpkt.
- destinationID  in  WORD_WIDTH  packet destination.
- unit_done  in  1  downstream unit finished the current packet.
- en_QTU, en_MNI, en_KCH, en_reward  out  1 each  one-cycle enable pulses.
- iAmDestination  out  1  current packet is addressed to this node (held through WAIT).
- cur_type  out  3  type of the packet being dispatched.
- busy  out  1  state is not IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- drop_cnt, timeout_cnt  out  CNT_WIDTH each  saturating counters.
- overflow  out  1  sticky; set when a packet is dropped because the FIFO is full.

Behaviour:
- Reset: all outputs, counters, FIFO pointers and the overflow flag go to 0; state becomes IDLE. Reset mid-WAIT discards the in-flight and queued packets.
- Acceptance: evaluated at the edge where newpkt=1.
  - Reserved type or TYPE_MASK[type]=0: drop, drop_cnt+1, no overflow.
  - Otherwise push {type, match}, where match = (destinationID==myNodeID) or (destinationID==BCAST_ID).
  - FIFO full and no pop in the same cycle: drop, drop_cnt+1, overflow set.
  - FIFO full with a pop in the same cycle: push accepted; count unchanged.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if FIFO non-empty, pop the head into the current-packet register and go to ISSUE.
  - ISSUE: lasts exactly one cycle. Enables are decoded from the current register and are high only in this state.
  - ISSUE to IDLE if unit_done=1 in this cycle; otherwise ISSUE to WAIT with the timer cleared.
  - WAIT: unit_done returns to IDLE. When the timer reaches TIMEOUT-1 without done, return to IDLE and increment timeout_cnt.
  - unit_done is ignored in IDLE.
- Decode in ISSUE:
  - HB: en_MNI=1, en_reward=1.
  - CHE: en_KCH=1.
  - INV: en_KCH=1.
  - DATA: en_QTU=1, en_reward=1.
  - iAmDestination = stored match, valid from ISSUE through WAIT; 0 in IDLE.
  - cur_type holds the current type from ISSUE through WAIT; 0 in IDLE.
- Latency: newpkt sampled at edge k, with the FIFO empty and the FSM in IDLE, gives enables high in the cycle after edge k+1 (2 edges). Back-to-back packets incur one IDLE bubble between dispatches.
- Counters saturate at all-ones. The ID comparison is a full WORD_WIDTH equality.

Decomposition:
- Package pkt_dispatch_pkg:
  - type constants PKT_HB, PKT_CHE, PKT_INV, PKT_DATA;
  - state enum;
  - entry struct {type[2:0], match}.
- Sub-module pkt_fifo: synchronous FIFO with count output and same-cycle push/pop when full. The FSM, decode and counters stay in the top level.

Test Plan:
- HB with myNodeID=0x000C, destinationID=0x0000 → one-cycle en_MNI and en_reward pulse 2 edges after newpkt; iAmDestination=0; unit_done two cycles later → busy=0.
- CHE with destinationID=0x0008, then CHE with destinationID=0x000C → en_KCH each time; iAmDestination 0, then 1. A CHE with destinationID=0xFFFF gives iAmDestination=1.
- INV and DATA to 0x001C; type 3'b101; type 3'b011 with TYPE_MASK=8'h07 → INV gives en_KCH; the reserved and masked packets are not dispatched; drop_cnt=2 with TYPE_MASK=8'h07 (DATA with en_QTU+en_reward checked in a run with the default mask).
- Six packets back-to-back while unit_done is held low → fifo_count peaks at 4 (one packet dequeued into WAIT); 1 dropped; overflow=1. Each later timeout increments timeout_cnt; the queue drains in order.
- Force 2^CNT_WIDTH+3 drops → drop_cnt saturates at 0xFF.
- Assert rst during WAIT with 3 entries queued → next edge: busy=0, fifo_count=0, all enables and counters 0; no stale dispatch after rst falls.

Source files
------------

// File: rtl/pkt_dispatch_pkg.sv
// Shared definitions for the packet dispatch queue.
//   - packet type codes (3-bit; codes with bit 2 set are reserved)
//   - dispatch FSM state encoding
//   - FIFO entry layout: packet type plus destination-match flag
package pkt_dispatch_pkg;

    localparam logic [2:0] PKT_HB   = 3'd0;
    localparam logic [2:0] PKT_CHE  = 3'd1;
    localparam logic [2:0] PKT_INV  = 3'd2;
    localparam logic [2:0] PKT_DATA = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] ptype;
        logic       match;
    } pkt_entry_t;

    // Types 3'b1xx are reserved and never dispatched.
    function automatic logic is_reserved(input logic [2:0] t);
        return t[2];
    endfunction

endpackage

// File: rtl/pkt_dispatch_queue_fifo.sv
// Synchronous FIFO of pending packet entries.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (clears pointers/count)
//   push, wdata  - write request and entry; ignored when full unless a pop
//                  happens in the same cycle
//   pop, rdata   - read request and head entry (rdata is valid while !empty)
//   count        - occupancy, 0..DEPTH
//   full, empty  - occupancy flags
module pkt_fifo
    import pkt_dispatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  pkt_entry_t                 wdata,
    input  logic                       pop,
    output pkt_entry_t                 rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    pkt_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A pop frees the slot at the same edge, so a full FIFO can still
    // take a push when the head is read in that cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pkt_dispatch_queue.sv
// Packet dispatch queue: classifies incoming packets, drops reserved or
// masked types, buffers accepted ones and hands them one at a time to the
// downstream unit as one-cycle enable pulses, then waits for completion.
//
// Handshake: newpkt is a one-cycle strobe with no back-pressure; the packet
// is taken or dropped at that edge. After an enable pulse (ISSUE), the
// downstream unit answers with unit_done (any cycle from ISSUE onwards);
// with no answer the dispatch is abandoned after TIMEOUT cycles of WAIT.
// unit_done is ignored while IDLE.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   newpkt, fPktType,
//   myNodeID, destinationID  - packet strobe and its fields
//   unit_done                - downstream completion
//   en_QTU/en_MNI/en_KCH/
//   en_reward                - one-cycle enables, high only in ISSUE
//   iAmDestination, cur_type - current packet info, 0 in IDLE
//   busy                     - FSM not in IDLE
//   fifo_count               - pending entries
//   drop_cnt, timeout_cnt    - saturating statistics
//   overflow                 - sticky, set on a drop caused by a full FIFO
//   dbg_state                - current FSM state
module pkt_dispatch_queue
    import pkt_dispatch_pkg::*;
#(
    parameter int                    WORD_WIDTH = 16,
    parameter int                    FIFO_DEPTH = 4,
    parameter int                    CNT_WIDTH  = 8,
    parameter logic [7:0]            TYPE_MASK  = 8'h0F,
    parameter logic [WORD_WIDTH-1:0] BCAST_ID   = '1,
    parameter int                    TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          newpkt,
    input  logic [2:0]                    fPktType,
    input  logic [WORD_WIDTH-1:0]         myNodeID,
    input  logic [WORD_WIDTH-1:0]         destinationID,
    input  logic                          unit_done,
    output logic                          en_QTU,
    output logic                          en_MNI,
    output logic                          en_KCH,
    output logic                          en_reward,
    output logic                          iAmDestination,
    output logic [2:0]                    cur_type,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_WIDTH-1:0]          drop_cnt,
    output logic [CNT_WIDTH-1:0]          timeout_cnt,
    output logic                          overflow,
    output state_t                        dbg_state
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            timeout_hit;
    pkt_entry_t      cur_q;

    pkt_entry_t      push_entry;
    pkt_entry_t      head_entry;
    logic            fifo_full;
    logic            fifo_empty;
    logic            type_ok;
    logic            id_match;
    logic            pop_req;
    logic            push_req;
    logic            drop_type;
    logic            drop_full;

    // ------------------------------------------------------------------
    // Acceptance
    // ------------------------------------------------------------------
    assign type_ok  = !is_reserved(fPktType) && TYPE_MASK[fPktType];
    assign id_match = (destinationID == myNodeID) || (destinationID == BCAST_ID);

    assign pop_req   = (state_q == ST_IDLE) && !fifo_empty;
    assign push_req  = newpkt && type_ok && (!fifo_full || pop_req);
    assign drop_type = newpkt && !type_ok;
    assign drop_full = newpkt && type_ok && fifo_full && !pop_req;

    assign push_entry.ptype = fPktType;
    assign push_entry.match = id_match;

    pkt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata (push_entry),
        .pop   (pop_req),
        .rdata (head_entry),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Dispatch FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (pop_req) begin
                cur_q <= head_entry;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (unit_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                    timer_d = '0;
                end
            end
            ST_WAIT: begin
                if (unit_done) begin
                    state_d = ST_IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d     = ST_IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        en_QTU    = 1'b0;
        en_MNI    = 1'b0;
        en_KCH    = 1'b0;
        en_reward = 1'b0;
        if (state_q == ST_ISSUE) begin
            case (cur_q.ptype)
                PKT_HB: begin
                    en_MNI    = 1'b1;
                    en_reward = 1'b1;
                end
                PKT_CHE,
                PKT_INV: en_KCH = 1'b1;
                PKT_DATA: begin
                    en_QTU    = 1'b1;
                    en_reward = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign iAmDestination = busy && cur_q.match;
    assign cur_type       = busy ? cur_q.ptype : 3'd0;
    assign dbg_state      = state_q;

    // ------------------------------------------------------------------
    // Statistics; at most one drop can occur per cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt    <= '0;
            timeout_cnt <= '0;
            overflow    <= 1'b0;
        end else begin
            if ((drop_type || drop_full) && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (timeout_hit && (timeout_cnt != '1)) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
            if (drop_full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_dispatch_queue.sv
module tb_pkt_dispatch_queue;
    import pkt_dispatch_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        newpkt;
    logic [2:0]  fPktType;
    logic [15:0] myNodeID;
    logic [15:0] destinationID;
    logic        unit_done;

    always #5 clk = ~clk;

    // default-mask instance (a) and TYPE_MASK=8'h07 instance (b)
    logic        qtu_a, mni_a, kch_a, rew_a, iad_a, busy_a, ovf_a;
    logic [2:0]  ctype_a, fcnt_a;
    logic [7:0]  drop_a, tmo_a;
    state_t      st_a;
    logic        qtu_b, mni_b, kch_b, rew_b, iad_b, busy_b, ovf_b;
    logic [2:0]  ctype_b, fcnt_b;
    logic [7:0]  drop_b, tmo_b;
    state_t      st_b;

    pkt_dispatch_queue dut (
        .clk(clk), .rst(rst), .newpkt(newpkt), .fPktType(fPktType),
        .myNodeID(myNodeID), .destinationID(destinationID), .unit_done(unit_done),
        .en_QTU(qtu_a), .en_MNI(mni_a), .en_KCH(kch_a), .en_reward(rew_a),
        .iAmDestination(iad_a), .cur_type(ctype_a), .busy(busy_a),
        .fifo_count(fcnt_a), .drop_cnt(drop_a), .timeout_cnt(tmo_a),
        .overflow(ovf_a), .dbg_state(st_a)
    );

    pkt_dispatch_queue #(.TYPE_MASK(8'h07)) dut_m7 (
        .clk(clk), .rst(rst), .newpkt(newpkt), .fPktType(fPktType),
        .myNodeID(myNodeID), .destinationID(destinationID), .unit_done(unit_done),
        .en_QTU(qtu_b), .en_MNI(mni_b), .en_KCH(kch_b), .en_reward(rew_b),
        .iAmDestination(iad_b), .cur_type(ctype_b), .busy(busy_b),
        .fifo_count(fcnt_b), .drop_cnt(drop_b), .timeout_cnt(tmo_b),
        .overflow(ovf_b), .dbg_state(st_b)
    );

    wire [3:0] en_a = {qtu_a, mni_a, kch_a, rew_a};
    wire [3:0] en_b = {qtu_b, mni_b, kch_b, rew_b};

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [2:0] exp_q[$];
    int n_disp;
    int peak;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; newpkt = 1'b0; unit_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_pkt(input logic [2:0] t, input logic [15:0] me, input logic [15:0] dst);
        newpkt = 1'b1; fPktType = t; myNodeID = me; destinationID = dst;
    endtask

    // Called once per negedge in the queueing section: tracks peak occupancy
    // and checks every dispatch against the expected order.
    task automatic observe();
        if (32'(fcnt_a) > peak) peak = 32'(fcnt_a);
        if (en_a != 4'd0) begin
            if (exp_q.size() == 0) begin
                check("extra_dispatch", 32'(ctype_a), 32'hFFFF_FFFF);
            end else begin
                check("drain_order", 32'(ctype_a), 32'(exp_q.pop_front()));
            end
            check("tmo_at_issue", 32'(tmo_a), 32'(n_disp));
            n_disp++;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [2:0]  typ;
        logic [15:0] my_id;
        logic [15:0] dest;
        logic        rst_before;
        logic        use_m7;
        logic        exp_disp;
        logic [3:0]  exp_en;   // {QTU, MNI, KCH, reward}
        logic        exp_iad;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [3:0]  s_en;
        logic        s_iad, s_busy;
        logic [2:0]  s_type, s_cnt;
        state_t      s_st;
        logic        stale;

        rst = 1'b1; newpkt = 1'b0; unit_done = 1'b0;
        fPktType = 3'd0; myNodeID = 16'd0; destinationID = 16'd0;

        vecs[0] = '{"hb",       PKT_HB,   16'h000C, 16'h0000, 1'b0, 1'b0, 1'b1, 4'b0101, 1'b0};
        vecs[1] = '{"che_8",    PKT_CHE,  16'h000C, 16'h0008, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0};
        vecs[2] = '{"che_c",    PKT_CHE,  16'h000C, 16'h000C, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1};
        vecs[3] = '{"che_bc",   PKT_CHE,  16'h000C, 16'hFFFF, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1};
        vecs[4] = '{"data",     PKT_DATA, 16'h000C, 16'h001C, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b0};
        vecs[5] = '{"inv_m7",   PKT_INV,  16'h000C, 16'h001C, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b0};
        vecs[6] = '{"rsv_101",  3'b101,   16'h000C, 16'h001C, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
        vecs[7] = '{"data_m7",  PKT_DATA, 16'h000C, 16'h001C, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        check("rst_en",    32'(en_a),   32'd0);
        check("rst_busy",  32'(busy_a), 32'd0);
        check("rst_fcnt",  32'(fcnt_a), 32'd0);
        check("rst_drop",  32'(drop_a), 32'd0);
        check("rst_tmo",   32'(tmo_a),  32'd0);
        check("rst_ovf",   32'(ovf_a),  32'd0);
        check("rst_ctype", 32'(ctype_a), 32'd0);
        check("rst_iad",   32'(iad_a),  32'd0);

        // ---------------- table-driven single-packet vectors ----------------
        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            @(negedge clk);
            drive_pkt(vecs[i].typ, vecs[i].my_id, vecs[i].dest);
            @(negedge clk);
            newpkt = 1'b0;
            s_en  = vecs[i].use_m7 ? en_b : en_a;
            s_cnt = vecs[i].use_m7 ? fcnt_b : fcnt_a;
            check({vecs[i].name, "_gap_en"}, 32'(s_en), 32'd0);
            check({vecs[i].name, "_gap_fcnt"}, 32'(s_cnt), 32'(vecs[i].exp_disp));
            @(negedge clk);
            s_en   = vecs[i].use_m7 ? en_b : en_a;
            s_iad  = vecs[i].use_m7 ? iad_b : iad_a;
            s_type = vecs[i].use_m7 ? ctype_b : ctype_a;
            check({vecs[i].name, "_issue_en"}, 32'(s_en), 32'(vecs[i].exp_en));
            check({vecs[i].name, "_issue_iad"}, 32'(s_iad), 32'(vecs[i].exp_iad));
            check({vecs[i].name, "_issue_type"}, 32'(s_type),
                  vecs[i].exp_disp ? 32'(vecs[i].typ) : 32'd0);
            @(negedge clk);
            s_en   = vecs[i].use_m7 ? en_b : en_a;
            s_iad  = vecs[i].use_m7 ? iad_b : iad_a;
            s_busy = vecs[i].use_m7 ? busy_b : busy_a;
            s_st   = vecs[i].use_m7 ? st_b : st_a;
            check({vecs[i].name, "_wait_en"}, 32'(s_en), 32'd0);
            check({vecs[i].name, "_wait_busy"}, 32'(s_busy), 32'(vecs[i].exp_disp));
            check({vecs[i].name, "_wait_iad"}, 32'(s_iad), 32'(vecs[i].exp_iad));
            check({vecs[i].name, "_wait_state"}, 32'(s_st),
                  vecs[i].exp_disp ? 32'(ST_WAIT) : 32'(ST_IDLE));
            unit_done = 1'b1;
            @(negedge clk);
            unit_done = 1'b0;
            s_busy = vecs[i].use_m7 ? busy_b : busy_a;
            check({vecs[i].name, "_done_busy"}, 32'(s_busy), 32'd0);
        end
        // since the reset: INV, 3'b101, DATA
        check("drop_def",  32'(drop_a), 32'd1);
        check("drop_m7",   32'(drop_b), 32'd2);
        check("ovf_m7",    32'(ovf_b),  32'd0);

        // ---------------- done during ISSUE (and held through IDLE) ----------------
        do_reset();
        unit_done = 1'b1;
        drive_pkt(PKT_DATA, 16'h0001, 16'h0001);
        @(negedge clk);
        newpkt = 1'b0;
        @(negedge clk);
        check("issdone_en", 32'(en_a), 32'b1001);
        check("issdone_iad", 32'(iad_a), 32'd1);
        @(negedge clk);
        unit_done = 1'b0;
        check("issdone_busy", 32'(busy_a), 32'd0);
        check("issdone_tmo", 32'(tmo_a), 32'd0);

        // ---------------- six back-to-back, overflow, timeouts, order ----------------
        do_reset();
        n_disp = 0;
        peak   = 0;
        for (int i = 0; i < 6; i++) begin
            drive_pkt(3'(i % 4), 16'h0005, 16'h0007);
            if (i < 5) exp_q.push_back(3'(i % 4));
            @(negedge clk);
            observe();
        end
        newpkt = 1'b0;
        check("b2b_peak", 32'(peak), 32'd4);
        check("b2b_drop", 32'(drop_a), 32'd1);
        check("b2b_ovf",  32'(ovf_a),  32'd1);
        for (int c = 0; c < 1000 && !(n_disp == 5 && !busy_a); c++) begin
            @(negedge clk);
            observe();
        end
        check("drain_count", 32'(n_disp), 32'd5);
        check("drain_busy",  32'(busy_a), 32'd0);
        check("drain_tmo",   32'(tmo_a),  32'd5);
        check("drain_left",  32'(exp_q.size()), 32'd0);
        check("drain_fcnt",  32'(fcnt_a), 32'd0);

        // ---------------- drop counter saturation ----------------
        do_reset();
        for (int i = 0; i < 259; i++) begin
            drive_pkt(3'b100 + 3'(i % 4), 16'h0000, 16'h0000);
            @(negedge clk);
        end
        newpkt = 1'b0;
        @(negedge clk);
        check("sat_drop", 32'(drop_a), 32'hFF);
        check("sat_ovf",  32'(ovf_a),  32'd0);
        check("sat_busy", 32'(busy_a), 32'd0);

        // ---------------- reset during WAIT with three queued ----------------
        do_reset();
        drive_pkt(3'b110, 16'h0000, 16'h0000);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive_pkt(PKT_HB, 16'h0000, 16'h0000);
            @(negedge clk);
        end
        newpkt = 1'b0;
        @(negedge clk);
        check("pre_rst_fcnt", 32'(fcnt_a), 32'd3);
        check("pre_rst_st",   32'(st_a),   32'(ST_WAIT));
        check("pre_rst_drop", 32'(drop_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_fcnt", 32'(fcnt_a), 32'd0);
        check("mid_rst_en",   32'(en_a),   32'd0);
        check("mid_rst_drop", 32'(drop_a), 32'd0);
        check("mid_rst_tmo",  32'(tmo_a),  32'd0);
        check("mid_rst_ovf",  32'(ovf_a),  32'd0);
        check("mid_rst_iad",  32'(iad_a),  32'd0);
        stale = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (en_a != 4'd0 || busy_a) stale = 1'b1;
        end
        check("no_stale_dispatch", 32'(stale), 32'd0);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
